// File: rtl/jt12_pg_pm.sv
// jt12_pg_pm: JT12 operator phase generator, time-multiplexed over SLOTS operator slots
// Ports:
//   clk, rst_n, clk_en       clock, asynchronous active-low reset, pipeline/ring advance enable
//   fnum_I, block_I          F-number and octave of the slot entering stage I
//   lfo_mod_I, pms_I         LFO PM value {sign, magnitude} and PM sensitivity, stage I
//   dt_off_III, dt_neg_III   detune magnitude and sign for the slot at stage III
//   mul_IV                   frequency multiplier for the slot at stage IV
//   pg_rst_III               phase reset request for the slot at stage III
//   pg_stop                  accumulator freeze for the slot at stage V
//   keycode_III              keycode of the slot at stage III
//   phase_VI                 top OUTW accumulator bits of the slot at stage VI
module jt12_pg_pm #(
    parameter int SLOTS = 24,
    parameter int PHW   = 20,
    parameter int OUTW  = 10,
    parameter bit PMEN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [10:0]     fnum_I,
    input  logic [2:0]      block_I,
    input  logic [4:0]      lfo_mod_I,
    input  logic [2:0]      pms_I,
    input  logic [4:0]      dt_off_III,
    input  logic            dt_neg_III,
    input  logic [3:0]      mul_IV,
    input  logic            pg_rst_III,
    input  logic            pg_stop,
    output logic [4:0]      keycode_III,
    output logic [OUTW-1:0] phase_VI
);
    localparam logic [3:0] PM_DEPTH [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd12};

    logic [11:0]     fnum_pm_II_q, fnum_pm_II_d;
    logic [2:0]      block_II_q;
    logic [4:0]      keycode_II_q, keycode_II_d, keycode_III_q;
    logic [17:0]     phinc_III_q, phinc_III_d;
    logic [17:0]     phinc_IV_q, phinc_IV_d;
    logic            pg_rst_IV_q, pg_rst_V_q;
    logic [PHW-1:0]  phinc_V_q, phinc_V_d;
    logic [PHW-1:0]  ring_q [SLOTS];
    logic [PHW-1:0]  ring_out, phase_in;
    logic [OUTW-1:0] phase_VI_q;
    logic [3:0]      pm_depth;
    logic [14:0]     pm_prod;
    logic [8:0]      pm_off;
    logic [17:0]     fnum_ext;

    always_comb begin
        pm_depth     = PMEN ? PM_DEPTH[pms_I] : 4'd0;
        // 127 x 15 x 12 = 22860 at most, so 15 bits hold the product exactly
        pm_prod      = 15'(fnum_I[10:4]) * 15'(lfo_mod_I[3:0]) * 15'(pm_depth);
        pm_off       = 9'(pm_prod >> 6);
        // the offset never exceeds ~0.18 fnum, so neither direction can wrap
        fnum_pm_II_d = lfo_mod_I[4] ? {1'b0, fnum_I} - {3'd0, pm_off}
                                    : {1'b0, fnum_I} + {3'd0, pm_off};
        keycode_II_d = {block_I, fnum_I[10], fnum_I[10] ? |fnum_I[9:7] : &fnum_I[9:7]};
        fnum_ext     = {6'd0, fnum_pm_II_q};
        phinc_III_d  = block_II_q == 3'd0 ? fnum_ext >> 1 : fnum_ext << (block_II_q - 3'd1);
        phinc_IV_d   = dt_neg_III ? phinc_III_q - {13'd0, dt_off_III}
                                  : phinc_III_q + {13'd0, dt_off_III};
        phinc_V_d    = mul_IV == 4'd0 ? PHW'(phinc_IV_q >> 1) : PHW'(phinc_IV_q) * PHW'(mul_IV);
        // the ring tail holds this slot's phase from one revolution ago
        ring_out     = ring_q[SLOTS-1];
        phase_in     = pg_rst_V_q ? '0 : pg_stop ? ring_out : ring_out + phinc_V_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnum_pm_II_q  <= '0;
            block_II_q    <= '0;
            keycode_II_q  <= '0;
            keycode_III_q <= '0;
            phinc_III_q   <= '0;
            phinc_IV_q    <= '0;
            pg_rst_IV_q   <= 1'b0;
            phinc_V_q     <= '0;
            pg_rst_V_q    <= 1'b0;
            phase_VI_q    <= '0;
            for (int i = 0; i < SLOTS; i++) ring_q[i] <= '0;
        end else if (clk_en) begin
            fnum_pm_II_q  <= fnum_pm_II_d;
            block_II_q    <= block_I;
            keycode_II_q  <= keycode_II_d;
            keycode_III_q <= keycode_II_q;
            phinc_III_q   <= phinc_III_d;
            phinc_IV_q    <= phinc_IV_d;
            pg_rst_IV_q   <= pg_rst_III;
            phinc_V_q     <= phinc_V_d;
            pg_rst_V_q    <= pg_rst_IV_q;
            phase_VI_q    <= phase_in[PHW-1 -: OUTW];
            ring_q[0]     <= phase_in;
            for (int i = 1; i < SLOTS; i++) ring_q[i] <= ring_q[i-1];
        end
    end

    assign keycode_III = keycode_III_q;
    assign phase_VI    = phase_VI_q;
endmodule

// File: tb/tb_jt12_pg_pm.sv
// tb_jt12_pg_pm: scoreboard bench for jt12_pg_pm with hand-computed phase increments
module tb_jt12_pg_pm;
    typedef struct {
        logic [10:0] fnum;
        logic [2:0]  blk;
        logic [4:0]  lfo;
        logic [2:0]  pms;
        logic [4:0]  dt;
        logic        dtn;
        logic [3:0]  mul;
        logic [19:0] inc;
        logic [4:0]  kc;
    } vec_t;

    typedef struct {
        int         due;
        logic [9:0] exp;
        int         slot;
    } sb_t;

    logic        clk = 1'b0, rst_n = 1'b1, clk_en = 1'b0;
    logic [10:0] fnum_I = '0;
    logic [2:0]  block_I = '0, pms_I = '0;
    logic [4:0]  lfo_mod_I = '0, dt_off_III = '0;
    logic        dt_neg_III = 1'b0, pg_rst_III = 1'b0, pg_stop = 1'b0;
    logic [3:0]  mul_IV = '0;
    logic [4:0]  keycode_III;
    logic [9:0]  phase_VI;

    vec_t        vt [8];
    int          hv [4096];
    bit          hr [4096];
    bit          hs [4096];
    logic [19:0] acc [24];
    sb_t         qph[$], qkc[$];
    int          nissue = 0, edges = 0, total = 0, bad = 0;
    logic [9:0]  last_ph = '0, last_kc = '0;

    jt12_pg_pm dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .fnum_I(fnum_I), .block_I(block_I), .lfo_mod_I(lfo_mod_I), .pms_I(pms_I),
        .dt_off_III(dt_off_III), .dt_neg_III(dt_neg_III), .mul_IV(mul_IV),
        .pg_rst_III(pg_rst_III), .pg_stop(pg_stop),
        .keycode_III(keycode_III), .phase_VI(phase_VI)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int slot, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s slot=%0d edge=%0d: got %0h want %0h", nm, slot, edges, got, want);
        end
    endtask

    // Drives one slot at stage I and the late-stage controls of the slots issued 2..4 earlier.
    task automatic issue(input int v, input bit r, input bit s, input bit push);
        int sl;
        sl = nissue % 24;
        hv[nissue] = v; hr[nissue] = r; hs[nissue] = s;
        fnum_I = vt[v].fnum; block_I = vt[v].blk; lfo_mod_I = vt[v].lfo; pms_I = vt[v].pms;
        if (nissue >= 2) begin
            dt_off_III = vt[hv[nissue-2]].dt; dt_neg_III = vt[hv[nissue-2]].dtn; pg_rst_III = hr[nissue-2];
        end else begin
            dt_off_III = '0; dt_neg_III = 1'b0; pg_rst_III = 1'b0;
        end
        if (nissue >= 3) mul_IV = vt[hv[nissue-3]].mul; else mul_IV = 4'd0;
        if (nissue >= 4) pg_stop = hs[nissue-4]; else pg_stop = 1'b0;
        acc[sl] = r ? 20'd0 : s ? acc[sl] : acc[sl] + vt[v].inc;
        if (push) begin
            qph.push_back('{edges + 5, acc[sl][19:10], sl});
            qkc.push_back('{edges + 2, {5'd0, vt[v].kc}, sl});
        end
        nissue++;
        @(negedge clk);
    endtask

    // After reset the pipeline holds zeros, so the first four outputs and first keycode read 0.
    task automatic restart();
        nissue = 0;
        for (int i = 0; i < 24; i++) acc[i] = '0;
        qph.delete();
        qkc.delete();
        for (int k = 1; k <= 4; k++) qph.push_back('{edges + k, 10'd0, -1});
        qkc.push_back('{edges + 1, 10'd0, -1});
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n && clk_en) begin
            edges++;
            #1;
            while (qph.size() > 0 && qph[0].due <= edges) begin
                chk("phase", qph[0].slot, 32'(phase_VI), 32'(qph[0].exp));
                last_ph = qph[0].exp;
                void'(qph.pop_front());
            end
            while (qkc.size() > 0 && qkc[0].due <= edges) begin
                chk("keycode", qkc[0].slot, 32'(keycode_III), 32'(qkc[0].exp));
                last_kc = qkc[0].exp;
                void'(qkc.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            fnum     blk   lfo       pms   dt    dtn   mul    inc          kc
        vt[0] = '{11'h400, 3'd4, 5'b00000, 3'd0, 5'd0, 1'b0, 4'd1,  20'h02000, 5'h12};
        vt[1] = '{11'h400, 3'd4, 5'b01111, 3'd7, 5'd0, 1'b0, 4'd1,  20'h025A0, 5'h12};
        vt[2] = '{11'h400, 3'd4, 5'b11111, 3'd7, 5'd0, 1'b0, 4'd1,  20'h01A60, 5'h12};
        vt[3] = '{11'h7FF, 3'd7, 5'b00000, 3'd0, 5'd0, 1'b0, 4'd15, 20'hDFC40, 5'h1F};
        vt[4] = '{11'h202, 3'd0, 5'b00000, 3'd0, 5'd0, 1'b0, 4'd0,  20'h00080, 5'h00};
        vt[5] = '{11'h005, 3'd0, 5'b00000, 3'd0, 5'd4, 1'b1, 4'd1,  20'h3FFFE, 5'h00};
        vt[6] = '{11'h100, 3'd1, 5'b00000, 3'd0, 5'd7, 1'b0, 4'd3,  20'h00315, 5'h04};
        vt[7] = '{11'h380, 3'd2, 5'b11000, 3'd3, 5'd0, 1'b0, 4'd2,  20'h00DAC, 5'h09};
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase", -1, 32'(phase_VI), 32'd0);
        chk("reset_keycode", -1, 32'(keycode_III), 32'd0);
        rst_n = 1'b1;
        clk_en = 1'b1;
        restart();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 24; k++) issue(0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 12; r++)
            for (int k = 0; k < 24; k++) begin
                if (r == 9 && k == 10) begin
                    clk_en = 1'b0;
                    repeat (7) begin
                        @(negedge clk);
                        chk("stall_phase", -1, 32'(phase_VI), 32'(last_ph));
                        chk("stall_keycode", -1, 32'(keycode_III), 32'(last_kc));
                    end
                    clk_en = 1'b1;
                end
                issue(k % 8, k == 3 && r == 3, k == 3 && (r == 3 || (r >= 5 && r <= 7)), 1'b1);
            end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_phase", -1, 32'(phase_VI), 32'd0);
        chk("async_reset_keycode", -1, 32'(keycode_III), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        restart();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 24; k++) issue(0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) issue(0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("drain_phase", -1, 32'(qph.size()), 32'd0);
        chk("drain_keycode", -1, 32'(qkc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
